// File: rtl/multi_channel_debounce_pkg.sv
// multi_channel_debounce_pkg: shared defaults, level-FSM state type and width helper for the debouncer
package multi_channel_debounce_pkg;

    // Smallest bit width able to hold the value v (at least 1 bit).
    function automatic int bits_for(input int unsigned v);
        return (v < 2) ? 1 : $clog2(v + 1);
    endfunction

    localparam int DEF_NUM_CH      = 4;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_THRESH_HI   = 10000000;
    localparam int DEF_THRESH_LO   = 2000000;
    localparam int DEF_CNT_W       = bits_for(DEF_THRESH_HI);
    localparam bit DEF_REPEAT_EN   = 1'b0;
    // 250 ms between repeat strobes at a 100 MHz clock.
    localparam int DEF_REPEAT_PER  = 25000000;

    typedef enum logic {
        LVL_LOW  = 1'b0,
        LVL_HIGH = 1'b1
    } lvl_state_t;

endpackage

// File: rtl/debounce_channel.sv
// debounce_channel: one button channel - synchroniser, saturating integrator, hysteresis level FSM, strobes, auto-repeat
module debounce_channel
    import multi_channel_debounce_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int THRESH_HI   = DEF_THRESH_HI,
    parameter int THRESH_LO   = DEF_THRESH_LO,
    parameter bit REPEAT_EN   = DEF_REPEAT_EN,
    parameter int REPEAT_PER  = DEF_REPEAT_PER
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic level,
    output logic rise,
    output logic fall,
    output logic press_evt
);

    // The repeat timer is sized from its own period so a long repeat interval
    // never has to share the integrator width.
    localparam int RPT_W = bits_for(REPEAT_PER - 1);
    localparam logic [CNT_W-1:0] HI       = CNT_W'(THRESH_HI);
    localparam logic [CNT_W-1:0] LO       = CNT_W'(THRESH_LO);
    localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_PER - 1);

    logic [SYNC_STAGES-1:0] sync;
    logic                   s;
    logic [CNT_W-1:0]       cnt;
    lvl_state_t             state;
    lvl_state_t             next_state;
    logic                   level_d;
    logic [RPT_W-1:0]       rpt;
    logic                   rpt_hit;

    assign s = sync[SYNC_STAGES-1];

    // Plain flop chain bringing the asynchronous button into the clock domain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync <= '0;
        else     sync <= {sync[SYNC_STAGES-2:0], btn};
    end

    // Up/down integrator that saturates at HI and at zero instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)    cnt <= '0;
        else if (s) cnt <= (cnt >= HI) ? HI : cnt + 1'b1;
        else        cnt <= (cnt == '0) ? '0 : cnt - 1'b1;
    end

    // Level FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= LVL_LOW;
        else     state <= next_state;
    end

    // Hysteresis: assert at the ceiling, release only once the count has fallen to LO.
    always_comb begin
        next_state = state;
        if (state == LVL_LOW && cnt >= HI)       next_state = LVL_HIGH;
        else if (state == LVL_HIGH && cnt <= LO) next_state = LVL_LOW;
    end

    // Debounced level is the FSM state itself, so it is glitch-free.
    always_comb begin
        level = (state == LVL_HIGH);
    end

    // Previous level, used to derive the one-cycle edge strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) level_d <= 1'b0;
        else     level_d <= level;
    end

    assign rise    = level & ~level_d;
    assign fall    = ~level & level_d;
    assign rpt_hit = REPEAT_EN & level & (rpt == RPT_LAST);

    // Repeat timer restarts from the press edge and wraps at every repeat strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                  rpt <= '0;
        else if (!level || rise)  rpt <= '0;
        else if (rpt_hit)         rpt <= '0;
        else                      rpt <= rpt + 1'b1;
    end

    // Press strobe on the rising edge and on each repeat; gated by level so a
    // release coinciding with a repeat reports only the fall.
    always_comb begin
        press_evt = rise | rpt_hit;
    end

endmodule

// File: rtl/multi_channel_debounce.sv
// multi_channel_debounce: NUM_CH independent debounce channels wired side by side
module multi_channel_debounce
    import multi_channel_debounce_pkg::*;
#(
    parameter int NUM_CH      = DEF_NUM_CH,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int THRESH_HI   = DEF_THRESH_HI,
    parameter int THRESH_LO   = DEF_THRESH_LO,
    parameter bit REPEAT_EN   = DEF_REPEAT_EN,
    parameter int REPEAT_PER  = DEF_REPEAT_PER
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] btn,
    output logic [NUM_CH-1:0] level,
    output logic [NUM_CH-1:0] rise,
    output logic [NUM_CH-1:0] fall,
    output logic [NUM_CH-1:0] press_evt
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        debounce_channel #(
            .SYNC_STAGES (SYNC_STAGES),
            .CNT_W       (CNT_W),
            .THRESH_HI   (THRESH_HI),
            .THRESH_LO   (THRESH_LO),
            .REPEAT_EN   (REPEAT_EN),
            .REPEAT_PER  (REPEAT_PER)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .btn       (btn[i]),
            .level     (level[i]),
            .rise      (rise[i]),
            .fall      (fall[i]),
            .press_evt (press_evt[i])
        );
    end

endmodule
